axi_mem_port: RTL and testbench
===============================

Name: axi_mem_port

Overview:
- Single-beat AXI4 master access engine, directly upstream of the CPU core's M_AXI bus.
- Instruction fetch and load/store issue one request at a time on a simple valid/ready request port.
- The block runs the AR/R or AW/W/B handshakes and returns one response pulse per request.
- It provides the dynamic AXI signals (addr, valid/ready, data, strobe, last) that the core currently ties to zero.

Parameters:
- ADDR_WIDTH, 32, AXI and request address width.
- DATA_WIDTH, 32, AXI and request data width; the strobe is DATA_WIDTH/8.

Ports:
- ACLK  in  1  clock.
- ARESETN  in  1  reset, asynchronous assert, active-low.
- REQ_VALID  in  1  request present.
- REQ_READY  out  1  request accepted when high together with REQ_VALID.
- REQ_WE  in  1  1 = write, 0 = read.
- REQ_ADDR  in  ADDR_WIDTH  byte address.
- REQ_WDATA  in  DATA_WIDTH  write data.
- REQ_WSTRB  in  DATA_WIDTH/8  write byte enables.
- RSP_VALID  out  1  one-cycle completion pulse.
- RSP_RDATA  out  DATA_WIDTH  read data, valid with RSP_VALID.
- RSP_ERR  out  1  AXI SLVERR/DECERR seen, valid with RSP_VALID.
- TXN_CNT  out  8  completed-transaction counter, for the STAT output.
- ERR_STICKY  out  1  set on any error response.
- M_AXI_AWADDR  out  ADDR_WIDTH
- M_AXI_AWVALID  out  1
- M_AXI_AWREADY  in  1
- M_AXI_WDATA  out  DATA_WIDTH
- M_AXI_WSTRB  out  DATA_WIDTH/8
- M_AXI_WLAST  out  1
- M_AXI_WVALID  out  1
- M_AXI_WREADY  in  1
- M_AXI_BRESP  in  2
- M_AXI_BVALID  in  1
- M_AXI_BREADY  out  1
- M_AXI_ARADDR  out  ADDR_WIDTH
- M_AXI_ARVALID  out  1
- M_AXI_ARREADY  in  1
- M_AXI_RDATA  in  DATA_WIDTH
- M_AXI_RRESP  in  2
- M_AXI_RLAST  in  1
- M_AXI_RVALID  in  1
- M_AXI_RREADY  out  1

Behaviour:
- Reset values: all registered outputs are 0; state is IDLE, so REQ_READY = 1.
- Static AXI fields are driven constant by the parent core: LEN = 0, SIZE = 3'b010, BURST = INCR, IDs = 0.
- FSM states: IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP.
- REQ_READY is combinational: 1 only in IDLE. REQ_VALID is ignored in every other state.
- Accept (IDLE and REQ_VALID): latch addr with the low 2 bits forced to 0, wdata and wstrb.
  - Read: go to RD_ADDR.
  - Write: go to WR_REQ.
- RD_ADDR:
  - ARVALID = 1 and ARADDR is held stable until ARREADY; no drop while waiting.
  - On handshake, go to RD_DATA.
- RD_DATA:
  - RREADY = 1.
  - On RVALID: capture RDATA, set ERR = RRESP[1], go to IDLE.
  - RLAST is ignored.
- WR_REQ:
  - AWVALID and WVALID both rise in the first WR_REQ cycle. WLAST = WVALID.
  - Each valid drops independently on its own handshake; AW and W may complete in either order or in the same cycle.
  - When both have completed, go to WR_RESP.
- WR_RESP:
  - BREADY = 1.
  - On BVALID: set ERR = BRESP[1], go to IDLE.
- Response:
  - RSP_VALID is registered: high for exactly 1 cycle, in the first cycle back in IDLE.
  - RSP_RDATA holds its last read value until the next read completes; it is 0 after reset.
  - RSP_RDATA is don't-care for writes.
- Back-to-back: a new request may be accepted in the same cycle that RSP_VALID is high.
- Minimum read latency, with ARREADY and RVALID already high: accept at cycle 0, ARVALID at cycle 1, RREADY at cycle 2, RSP_VALID at cycle 3.
- Minimum write latency is the same: 3 cycles.
- TXN_CNT increments by 1 on every RSP_VALID and wraps 255 -> 0.
- ERR_STICKY sets on RSP_VALID with RSP_ERR = 1 and clears only on reset.
- A write with REQ_WSTRB = 0 still issues a full AXI write.
- Reset mid-transaction: all valids and readies drop asynchronously and no RSP_VALID is produced. The interconnect shares ARESETN.

Decomposition:
- Package clangpu_pkg holds:
  - the state enum encoding;
  - AXI constants: RESP_OKAY = 2'b00, SIZE_WORD = 3'b010, BURST_INCR = 2'b01.
- No sub-module; the block is a single FSM with capture registers.
- The core instantiates axi_mem_port and keeps only the constant ties.

Test Plan:
- Read, all readies held high, RDATA = 32'hDEADBEEF, RRESP = 0 -> ARADDR = 32'h0000_1000; RSP_VALID at cycle 3 with RSP_RDATA = DEADBEEF and RSP_ERR = 0; TXN_CNT = 1.
- Read of addr 32'h0000_1003 with ARREADY delayed 4 cycles -> ARADDR = 32'h0000_1000, ARVALID high for 5 cycles and stable throughout; REQ_READY = 0 the whole time.
- Write where WREADY arrives 2 cycles before AWREADY -> WVALID drops first, AWVALID holds; BREADY rises only after both handshakes; BRESP = 2'b10 gives RSP_ERR = 1 and ERR_STICKY = 1.
- Back-to-back: read issued in the same cycle as the prior write's RSP_VALID -> accepted that cycle; two RSP_VALID pulses, TXN_CNT = 2.
- 256 transactions -> TXN_CNT wraps to 0.
- ARESETN pulsed low during RD_DATA -> all valids and readies are 0 immediately; no RSP_VALID; REQ_READY = 1 after release.

Source files
------------

// File: rtl/clangpu_pkg.sv
// Shared types and AXI constants for the single-beat AXI master port.
// The core uses SIZE_WORD and BURST_INCR for its constant AXI ties.
package clangpu_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RD_ADDR = 3'd1,
    ST_RD_DATA = 3'd2,
    ST_WR_REQ  = 3'd3,
    ST_WR_RESP = 3'd4
  } state_t;

  localparam logic [1:0] RESP_OKAY  = 2'b00;
  localparam logic [2:0] SIZE_WORD  = 3'b010;
  localparam logic [1:0] BURST_INCR = 2'b01;

endpackage

// File: rtl/axi_mem_port_if.sv
// Request/response port plus the dynamic M_AXI signals of axi_mem_port.
// Handshake rule on every channel: a transfer happens on a rising clock edge where valid and ready are both high.
interface axi_mem_port_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  localparam int STRB_WIDTH = DATA_WIDTH / 8;

  logic                  REQ_VALID;
  logic                  REQ_READY;
  logic                  REQ_WE;
  logic [ADDR_WIDTH-1:0] REQ_ADDR;
  logic [DATA_WIDTH-1:0] REQ_WDATA;
  logic [STRB_WIDTH-1:0] REQ_WSTRB;
  logic                  RSP_VALID;
  logic [DATA_WIDTH-1:0] RSP_RDATA;
  logic                  RSP_ERR;
  logic [7:0]            TXN_CNT;
  logic                  ERR_STICKY;

  logic [ADDR_WIDTH-1:0] M_AXI_AWADDR;
  logic                  M_AXI_AWVALID;
  logic                  M_AXI_AWREADY;
  logic [DATA_WIDTH-1:0] M_AXI_WDATA;
  logic [STRB_WIDTH-1:0] M_AXI_WSTRB;
  logic                  M_AXI_WLAST;
  logic                  M_AXI_WVALID;
  logic                  M_AXI_WREADY;
  logic [1:0]            M_AXI_BRESP;
  logic                  M_AXI_BVALID;
  logic                  M_AXI_BREADY;
  logic [ADDR_WIDTH-1:0] M_AXI_ARADDR;
  logic                  M_AXI_ARVALID;
  logic                  M_AXI_ARREADY;
  logic [DATA_WIDTH-1:0] M_AXI_RDATA;
  logic [1:0]            M_AXI_RRESP;
  logic                  M_AXI_RLAST;
  logic                  M_AXI_RVALID;
  logic                  M_AXI_RREADY;

  modport master (
    input  REQ_VALID, REQ_WE, REQ_ADDR, REQ_WDATA, REQ_WSTRB,
    output REQ_READY, RSP_VALID, RSP_RDATA, RSP_ERR, TXN_CNT, ERR_STICKY,
    output M_AXI_AWADDR, M_AXI_AWVALID, M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WLAST,
    output M_AXI_WVALID, M_AXI_BREADY, M_AXI_ARADDR, M_AXI_ARVALID, M_AXI_RREADY,
    input  M_AXI_AWREADY, M_AXI_WREADY, M_AXI_BRESP, M_AXI_BVALID,
    input  M_AXI_ARREADY, M_AXI_RDATA, M_AXI_RRESP, M_AXI_RLAST, M_AXI_RVALID
  );

  modport slave (
    output REQ_VALID, REQ_WE, REQ_ADDR, REQ_WDATA, REQ_WSTRB,
    input  REQ_READY, RSP_VALID, RSP_RDATA, RSP_ERR, TXN_CNT, ERR_STICKY,
    input  M_AXI_AWADDR, M_AXI_AWVALID, M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WLAST,
    input  M_AXI_WVALID, M_AXI_BREADY, M_AXI_ARADDR, M_AXI_ARVALID, M_AXI_RREADY,
    output M_AXI_AWREADY, M_AXI_WREADY, M_AXI_BRESP, M_AXI_BVALID,
    output M_AXI_ARREADY, M_AXI_RDATA, M_AXI_RRESP, M_AXI_RLAST, M_AXI_RVALID
  );

endinterface

// File: rtl/axi_mem_port.sv
// Single-beat AXI4 master: one request at a time, AR/R or AW/W/B, one response pulse per request.
// All channel valids/readies decode from state, so the asynchronous reset drops them at once.
module axi_mem_port
  import clangpu_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic            ACLK,
  input  logic            ARESETN,
  axi_mem_port_if.master  bus,
  output state_t          dbg_state
);
  localparam int STRB_WIDTH = DATA_WIDTH / 8;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [STRB_WIDTH-1:0] wstrb_q;
  logic                  aw_done_q, w_done_q;
  logic                  rsp_valid_q, rsp_err_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic [7:0]            txn_cnt_q;
  logic                  err_sticky_q;

  logic accept, aw_fire, w_fire, done, done_err, awvalid, wvalid;

  always_comb begin
    state_d  = state_q;
    accept   = 1'b0;
    aw_fire  = 1'b0;
    w_fire   = 1'b0;
    done     = 1'b0;
    done_err = 1'b0;
    awvalid  = (state_q == ST_WR_REQ) && !aw_done_q;
    wvalid   = (state_q == ST_WR_REQ) && !w_done_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.REQ_VALID) begin
          accept  = 1'b1;
          state_d = bus.REQ_WE ? ST_WR_REQ : ST_RD_ADDR;
        end
      end
      ST_RD_ADDR: begin
        if (bus.M_AXI_ARREADY) state_d = ST_RD_DATA;
      end
      ST_RD_DATA: begin
        if (bus.M_AXI_RVALID) begin
          done     = 1'b1;
          done_err = bus.M_AXI_RRESP[1];
          state_d  = ST_IDLE;
        end
      end
      ST_WR_REQ: begin
        // AW and W complete independently; move on once both have been taken.
        aw_fire = awvalid && bus.M_AXI_AWREADY;
        w_fire  = wvalid && bus.M_AXI_WREADY;
        if ((aw_done_q || aw_fire) && (w_done_q || w_fire)) state_d = ST_WR_RESP;
      end
      ST_WR_RESP: begin
        if (bus.M_AXI_BVALID) begin
          done     = 1'b1;
          done_err = bus.M_AXI_BRESP[1];
          state_d  = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state_q      <= ST_IDLE;
      addr_q       <= '0;
      wdata_q      <= '0;
      wstrb_q      <= '0;
      aw_done_q    <= 1'b0;
      w_done_q     <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_err_q    <= 1'b0;
      rdata_q      <= '0;
      txn_cnt_q    <= '0;
      err_sticky_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      rsp_valid_q <= done;
      if (accept) begin
        addr_q    <= {bus.REQ_ADDR[ADDR_WIDTH-1:2], 2'b00};
        wdata_q   <= bus.REQ_WDATA;
        wstrb_q   <= bus.REQ_WSTRB;
        aw_done_q <= 1'b0;
        w_done_q  <= 1'b0;
      end else begin
        if (aw_fire) aw_done_q <= 1'b1;
        if (w_fire)  w_done_q  <= 1'b1;
      end
      if (done) begin
        rsp_err_q <= done_err;
        txn_cnt_q <= txn_cnt_q + 8'd1;
        if (done_err) err_sticky_q <= 1'b1;
        if (state_q == ST_RD_DATA) rdata_q <= bus.M_AXI_RDATA;
      end
    end
  end

  assign bus.REQ_READY     = (state_q == ST_IDLE);
  assign bus.RSP_VALID     = rsp_valid_q;
  assign bus.RSP_RDATA     = rdata_q;
  assign bus.RSP_ERR       = rsp_err_q;
  assign bus.TXN_CNT       = txn_cnt_q;
  assign bus.ERR_STICKY    = err_sticky_q;

  assign bus.M_AXI_ARADDR  = addr_q;
  assign bus.M_AXI_ARVALID = (state_q == ST_RD_ADDR);
  assign bus.M_AXI_RREADY  = (state_q == ST_RD_DATA);
  assign bus.M_AXI_AWADDR  = addr_q;
  assign bus.M_AXI_AWVALID = awvalid;
  assign bus.M_AXI_WDATA   = wdata_q;
  assign bus.M_AXI_WSTRB   = wstrb_q;
  assign bus.M_AXI_WVALID  = wvalid;
  assign bus.M_AXI_WLAST   = wvalid;
  assign bus.M_AXI_BREADY  = (state_q == ST_WR_RESP);

  assign dbg_state = state_q;

  // Single-beat reads make RLAST redundant; only the error bit of a response matters.
  logic unused_ok;
  assign unused_ok = &{1'b0, bus.M_AXI_RLAST, bus.M_AXI_RRESP[0], bus.M_AXI_BRESP[0],
                       bus.REQ_ADDR[1:0], RESP_OKAY, SIZE_WORD, BURST_INCR};

endmodule

// File: tb/tb_axi_mem_port.sv
// Bench for axi_mem_port: scenario tasks drive the request port and a scripted AXI slave,
// and a response monitor compares every RSP_VALID against an expected queue.
module tb_axi_mem_port;
  import clangpu_pkg::*;

  localparam int AW      = 32;
  localparam int DW      = 32;
  localparam int SW      = DW / 8;
  localparam int TIMEOUT = 200;

  logic   clk;
  logic   rst_n;
  state_t dbg_state;

  axi_mem_port_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  axi_mem_port #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .ACLK      (clk),
    .ARESETN   (rst_n),
    .bus       (bus.master),
    .dbg_state (dbg_state)
  );

  int errors    = 0;
  int checks    = 0;
  int rsp_count = 0;
  int exp_txn   = 0;
  logic exp_sticky = 1'b0;
  logic prev_rsp   = 1'b0;
  logic [DW+1:0] mon_exp;
  // Entry layout: {is_read, err, rdata}
  logic [DW+1:0] exp_q[$];

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required finish earlier");
    $fatal(1);
  end

  // ---------------- response monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.RSP_VALID) begin
        rsp_count++;
        checks++;
        if (prev_rsp) begin
          errors++;
          $display("FAIL rsp_pulse_width: RSP_VALID=1 in two consecutive cycles, required 1-cycle pulse");
        end
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL rsp_unexpected: RSP_VALID=1 with no outstanding request, required 0");
        end else begin
          mon_exp = exp_q.pop_front();
          exp_txn = (exp_txn + 1) % 256;
          if (mon_exp[DW]) exp_sticky = 1'b1;
          checks++;
          if (bus.RSP_ERR !== mon_exp[DW]) begin
            errors++;
            $display("FAIL rsp_err: got %b required %b", bus.RSP_ERR, mon_exp[DW]);
          end
          if (mon_exp[DW+1]) begin
            checks++;
            if (bus.RSP_RDATA !== mon_exp[DW-1:0]) begin
              errors++;
              $display("FAIL rsp_rdata: got %h required %h", bus.RSP_RDATA, mon_exp[DW-1:0]);
            end
          end
          checks++;
          if (bus.TXN_CNT !== exp_txn[7:0]) begin
            errors++;
            $display("FAIL txn_cnt: got %0d required %0d", bus.TXN_CNT, exp_txn[7:0]);
          end
          checks++;
          if (bus.ERR_STICKY !== exp_sticky) begin
            errors++;
            $display("FAIL err_sticky: got %b required %b", bus.ERR_STICKY, exp_sticky);
          end
        end
      end
      prev_rsp = bus.RSP_VALID;
    end else begin
      prev_rsp = 1'b0;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive_axi_idle();
    bus.REQ_VALID     = 1'b0;
    bus.REQ_WE        = 1'b0;
    bus.REQ_ADDR      = '0;
    bus.REQ_WDATA     = '0;
    bus.REQ_WSTRB     = '0;
    bus.M_AXI_AWREADY = 1'b0;
    bus.M_AXI_WREADY  = 1'b0;
    bus.M_AXI_BRESP   = 2'b00;
    bus.M_AXI_BVALID  = 1'b0;
    bus.M_AXI_ARREADY = 1'b0;
    bus.M_AXI_RDATA   = '0;
    bus.M_AXI_RRESP   = 2'b00;
    bus.M_AXI_RLAST   = 1'b0;
    bus.M_AXI_RVALID  = 1'b0;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    drive_axi_idle();
    repeat (3) @(posedge clk);
    exp_q.delete();
    exp_txn    = 0;
    exp_sticky = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Call at a negedge; returns 1 time unit after the accepting posedge.
  task automatic issue(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                       input logic [SW-1:0] wstrb, input logic err, input logic [DW-1:0] rdata);
    int n;
    bus.REQ_VALID = 1'b1;
    bus.REQ_WE    = we;
    bus.REQ_ADDR  = addr;
    bus.REQ_WDATA = wdata;
    bus.REQ_WSTRB = wstrb;
    exp_q.push_back({~we, err, rdata});
    n = 0;
    while (bus.REQ_READY !== 1'b1 && n < TIMEOUT) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= TIMEOUT) begin
      errors++;
      $display("FAIL accept_timeout: REQ_READY=%b after %0d cycles, required 1", bus.REQ_READY, n);
    end
    @(posedge clk);
    #1;
    bus.REQ_VALID = 1'b0;
    bus.REQ_WE    = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < TIMEOUT) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL rsp_timeout: %0d responses outstanding, required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    drive_axi_idle();
    repeat (2) @(negedge clk);
    checks++;
    if ({bus.M_AXI_ARVALID, bus.M_AXI_RREADY, bus.M_AXI_AWVALID, bus.M_AXI_WVALID, bus.M_AXI_WLAST,
         bus.M_AXI_BREADY, bus.RSP_VALID, bus.RSP_ERR, bus.ERR_STICKY} !== 9'b0) begin
      errors++;
      $display("FAIL reset_ctrl: ar/r/aw/w/wl/b/rsp/err/sticky=%b required 0", {bus.M_AXI_ARVALID,
               bus.M_AXI_RREADY, bus.M_AXI_AWVALID, bus.M_AXI_WVALID, bus.M_AXI_WLAST,
               bus.M_AXI_BREADY, bus.RSP_VALID, bus.RSP_ERR, bus.ERR_STICKY});
    end
    checks++;
    if (bus.REQ_READY !== 1'b1 || dbg_state !== ST_IDLE) begin
      errors++;
      $display("FAIL reset_ready: REQ_READY=%b state=%0d required 1/IDLE", bus.REQ_READY, dbg_state);
    end
    checks++;
    if (bus.RSP_RDATA !== '0 || bus.TXN_CNT !== 8'd0 || bus.M_AXI_ARADDR !== '0 || bus.M_AXI_WDATA !== '0
        || bus.M_AXI_WSTRB !== '0) begin
      errors++;
      $display("FAIL reset_data: rdata=%h cnt=%0d araddr=%h wdata=%h wstrb=%h required 0",
               bus.RSP_RDATA, bus.TXN_CNT, bus.M_AXI_ARADDR, bus.M_AXI_WDATA, bus.M_AXI_WSTRB);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_read_basic();
    bus.M_AXI_ARREADY = 1'b1;
    bus.M_AXI_RVALID  = 1'b1;
    bus.M_AXI_RDATA   = 32'hDEADBEEF;
    bus.M_AXI_RRESP   = 2'b00;
    @(negedge clk);
    issue(1'b0, 32'h0000_1000, '0, '0, 1'b0, 32'hDEADBEEF);
    @(negedge clk);
    checks++;
    if (bus.M_AXI_ARVALID !== 1'b1 || bus.M_AXI_ARADDR !== 32'h0000_1000) begin
      errors++;
      $display("FAIL rd_cycle1: arvalid=%b araddr=%h required 1/00001000", bus.M_AXI_ARVALID, bus.M_AXI_ARADDR);
    end
    @(negedge clk);
    checks++;
    if (bus.M_AXI_RREADY !== 1'b1 || bus.M_AXI_ARVALID !== 1'b0) begin
      errors++;
      $display("FAIL rd_cycle2: rready=%b arvalid=%b required 1/0", bus.M_AXI_RREADY, bus.M_AXI_ARVALID);
    end
    @(negedge clk);
    checks++;
    if (bus.RSP_VALID !== 1'b1 || bus.RSP_RDATA !== 32'hDEADBEEF || bus.TXN_CNT !== 8'd1) begin
      errors++;
      $display("FAIL rd_cycle3: rsp_valid=%b rdata=%h cnt=%0d required 1/deadbeef/1",
               bus.RSP_VALID, bus.RSP_RDATA, bus.TXN_CNT);
    end
    wait_done();
  endtask

  task automatic test_read_ar_delay();
    bus.M_AXI_ARREADY = 1'b0;
    bus.M_AXI_RVALID  = 1'b1;
    bus.M_AXI_RDATA   = 32'h1234_5678;
    @(negedge clk);
    issue(1'b0, 32'h0000_1003, '0, '0, 1'b0, 32'h1234_5678);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (bus.M_AXI_ARVALID !== 1'b1 || bus.M_AXI_ARADDR !== 32'h0000_1000 || bus.REQ_READY !== 1'b0) begin
        errors++;
        $display("FAIL ar_hold[%0d]: arvalid=%b araddr=%h req_ready=%b required 1/00001000/0",
                 i, bus.M_AXI_ARVALID, bus.M_AXI_ARADDR, bus.REQ_READY);
      end
      if (i == 4) bus.M_AXI_ARREADY = 1'b1;
    end
    @(negedge clk);
    checks++;
    if (bus.M_AXI_ARVALID !== 1'b0 || bus.M_AXI_RREADY !== 1'b1 || bus.REQ_READY !== 1'b0) begin
      errors++;
      $display("FAIL ar_release: arvalid=%b rready=%b req_ready=%b required 0/1/0",
               bus.M_AXI_ARVALID, bus.M_AXI_RREADY, bus.REQ_READY);
    end
    wait_done();
  endtask

  task automatic test_write_w_first();
    bus.M_AXI_AWREADY = 1'b0;
    bus.M_AXI_WREADY  = 1'b0;
    bus.M_AXI_BVALID  = 1'b0;
    bus.M_AXI_BRESP   = 2'b10;
    @(negedge clk);
    issue(1'b1, 32'h0000_2006, 32'hA5A5_0F0F, 4'b0110, 1'b1, '0);
    @(negedge clk);
    checks++;
    if ({bus.M_AXI_AWVALID, bus.M_AXI_WVALID, bus.M_AXI_WLAST, bus.M_AXI_BREADY} !== 4'b1110
        || bus.M_AXI_AWADDR !== 32'h0000_2004 || bus.M_AXI_WDATA !== 32'hA5A5_0F0F
        || bus.M_AXI_WSTRB !== 4'b0110) begin
      errors++;
      $display("FAIL wr_issue: aw/w/wl/b=%b awaddr=%h wdata=%h wstrb=%b required 1110/00002004/a5a50f0f/0110",
               {bus.M_AXI_AWVALID, bus.M_AXI_WVALID, bus.M_AXI_WLAST, bus.M_AXI_BREADY},
               bus.M_AXI_AWADDR, bus.M_AXI_WDATA, bus.M_AXI_WSTRB);
    end
    bus.M_AXI_WREADY = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      bus.M_AXI_WREADY = 1'b0;
      checks++;
      if ({bus.M_AXI_AWVALID, bus.M_AXI_WVALID, bus.M_AXI_WLAST, bus.M_AXI_BREADY} !== 4'b1000) begin
        errors++;
        $display("FAIL wr_w_first[%0d]: aw/w/wl/b=%b required 1000", i,
                 {bus.M_AXI_AWVALID, bus.M_AXI_WVALID, bus.M_AXI_WLAST, bus.M_AXI_BREADY});
      end
      if (i == 1) bus.M_AXI_AWREADY = 1'b1;
    end
    @(negedge clk);
    bus.M_AXI_AWREADY = 1'b0;
    checks++;
    if ({bus.M_AXI_AWVALID, bus.M_AXI_WVALID, bus.M_AXI_BREADY} !== 3'b001) begin
      errors++;
      $display("FAIL wr_bready: aw/w/b=%b required 001",
               {bus.M_AXI_AWVALID, bus.M_AXI_WVALID, bus.M_AXI_BREADY});
    end
    bus.M_AXI_BVALID = 1'b1;
    @(negedge clk);
    bus.M_AXI_BVALID = 1'b0;
    checks++;
    if (bus.RSP_VALID !== 1'b1 || bus.RSP_ERR !== 1'b1 || bus.ERR_STICKY !== 1'b1) begin
      errors++;
      $display("FAIL wr_slverr: rsp_valid=%b rsp_err=%b sticky=%b required 1/1/1",
               bus.RSP_VALID, bus.RSP_ERR, bus.ERR_STICKY);
    end
    wait_done();
    bus.M_AXI_BRESP = 2'b00;
  endtask

  task automatic test_write_zero_strb();
    bus.M_AXI_AWREADY = 1'b1;
    bus.M_AXI_WREADY  = 1'b1;
    bus.M_AXI_BVALID  = 1'b1;
    bus.M_AXI_BRESP   = 2'b00;
    @(negedge clk);
    issue(1'b1, 32'h0000_5000, 32'h0BAD_F00D, 4'b0000, 1'b0, '0);
    @(negedge clk);
    checks++;
    if (bus.M_AXI_AWVALID !== 1'b1 || bus.M_AXI_WVALID !== 1'b1 || bus.M_AXI_WSTRB !== 4'b0000) begin
      errors++;
      $display("FAIL wr_zero_strb: awvalid=%b wvalid=%b wstrb=%b required 1/1/0000",
               bus.M_AXI_AWVALID, bus.M_AXI_WVALID, bus.M_AXI_WSTRB);
    end
    wait_done();
  endtask

  task automatic test_back_to_back();
    int base;
    int n;
    apply_reset();
    bus.M_AXI_AWREADY = 1'b1;
    bus.M_AXI_WREADY  = 1'b1;
    bus.M_AXI_BVALID  = 1'b1;
    bus.M_AXI_BRESP   = 2'b00;
    bus.M_AXI_ARREADY = 1'b1;
    bus.M_AXI_RVALID  = 1'b1;
    bus.M_AXI_RDATA   = 32'hCAFE_F00D;
    bus.M_AXI_RRESP   = 2'b00;
    base = rsp_count;
    @(negedge clk);
    issue(1'b1, 32'h0000_3000, 32'h1111_2222, 4'hF, 1'b0, '0);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (bus.RSP_VALID !== 1'b1 && n < TIMEOUT);
    checks++;
    if (bus.RSP_VALID !== 1'b1 || bus.REQ_READY !== 1'b1) begin
      errors++;
      $display("FAIL b2b_ready: rsp_valid=%b req_ready=%b required 1/1", bus.RSP_VALID, bus.REQ_READY);
    end
    issue(1'b0, 32'h0000_3008, '0, '0, 1'b0, 32'hCAFE_F00D);
    checks++;
    if (dbg_state !== ST_RD_ADDR) begin
      errors++;
      $display("FAIL b2b_accept: state=%0d required %0d", dbg_state, ST_RD_ADDR);
    end
    wait_done();
    checks++;
    if (rsp_count - base !== 2 || bus.TXN_CNT !== 8'd2) begin
      errors++;
      $display("FAIL b2b_count: pulses=%0d cnt=%0d required 2/2", rsp_count - base, bus.TXN_CNT);
    end
  endtask

  task automatic test_wrap();
    logic [DW-1:0] rd;
    apply_reset();
    bus.M_AXI_ARREADY = 1'b1;
    bus.M_AXI_RVALID  = 1'b1;
    bus.M_AXI_RRESP   = 2'b00;
    for (int i = 0; i < 256; i++) begin
      rd = $urandom;
      bus.M_AXI_RDATA = rd;
      @(negedge clk);
      issue(1'b0, AW'($urandom_range(0, 16'hFFFF)), '0, '0, 1'b0, rd);
      wait_done();
      if (i == 254) begin
        checks++;
        if (bus.TXN_CNT !== 8'd255) begin
          errors++;
          $display("FAIL wrap_255: cnt=%0d required 255", bus.TXN_CNT);
        end
      end
    end
    checks++;
    if (bus.TXN_CNT !== 8'd0) begin
      errors++;
      $display("FAIL wrap_0: cnt=%0d required 0", bus.TXN_CNT);
    end
  endtask

  task automatic test_reset_mid();
    int base;
    bus.M_AXI_ARREADY = 1'b1;
    bus.M_AXI_RVALID  = 1'b0;
    @(negedge clk);
    issue(1'b0, 32'h0000_4000, '0, '0, 1'b0, 32'h5555_AAAA);
    repeat (2) @(negedge clk);
    checks++;
    if (bus.M_AXI_RREADY !== 1'b1) begin
      errors++;
      $display("FAIL mid_rd_data: rready=%b required 1", bus.M_AXI_RREADY);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.M_AXI_ARVALID, bus.M_AXI_RREADY, bus.M_AXI_AWVALID, bus.M_AXI_WVALID, bus.M_AXI_BREADY,
         bus.RSP_VALID} !== 6'b0 || dbg_state !== ST_IDLE) begin
      errors++;
      $display("FAIL mid_async: ar/r/aw/w/b/rsp=%b state=%0d required 0/IDLE", {bus.M_AXI_ARVALID,
               bus.M_AXI_RREADY, bus.M_AXI_AWVALID, bus.M_AXI_WVALID, bus.M_AXI_BREADY, bus.RSP_VALID},
               dbg_state);
    end
    exp_q.delete();
    exp_txn    = 0;
    exp_sticky = 1'b0;
    bus.M_AXI_RVALID = 1'b1;
    base = rsp_count;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.REQ_READY !== 1'b1) begin
      errors++;
      $display("FAIL mid_ready: REQ_READY=%b required 1", bus.REQ_READY);
    end
    repeat (5) @(negedge clk);
    checks++;
    if (rsp_count !== base || bus.TXN_CNT !== 8'd0) begin
      errors++;
      $display("FAIL mid_no_rsp: pulses=%0d cnt=%0d required 0/0", rsp_count - base, bus.TXN_CNT);
    end
    bus.M_AXI_RVALID = 1'b0;
  endtask

  // ---------------- sequence / report ----------------
  initial begin
    test_reset();
    test_read_basic();
    test_read_ar_delay();
    test_write_w_first();
    test_write_zero_strb();
    test_back_to_back();
    test_wrap();
    test_reset_mid();
    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
